flex_updown_counter: RTL and testbench

// - Parametrised successor to the lab up-counter: programmable-terminal counter with up/down

---
 rtl/flex_updown_counter.sv | 96 +++++++++
 tb/tb_flex_updown_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// flex_updown_counter
//   Programmable-terminal up/down counter. It supports a synchronous clear and a
//   synchronous load, and it either wraps or saturates at the ends of its range.
//   All outputs are registered, so there is no combinational path from any input
//   to any output.
//
// Ports
//   clk            rising-edge system clock
//   n_rst          asynchronous active-low reset
//   clear          synchronous clear of the count to 0 (highest priority)
//   load           synchronous load of load_val (takes priority over count_enable)
//   load_val       value written by load
//   count_enable   advance the count by one step this cycle
//   up_ndown       1 = count up, 0 = count down
//   sat_mode       1 = saturate at the range ends, 0 = wrap
//   rollover_val   terminal value R (unsigned)
//   count_out      current count
//   rollover_flag  high while count_out == rollover_val
//   wrap_pulse     high for the cycle after a wrapping step
module flex_updown_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    up_ndown,
    input  logic                    sat_mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] next_count;
    logic [NUM_CNT_BITS-1:0] dec_count;
    logic                    next_wrap;

    always_comb begin
        next_count = count_out;
        next_wrap  = 1'b0;
        dec_count  = count_out - ONE;
        if (clear) begin
            next_count = '0;
        end else if (load) begin
            next_count = load_val;
        end else if (count_enable) begin
            if (rollover_val == '0) begin
                // A zero terminal value pins the count at 0 and never wraps.
                next_count = '0;
            end else if (up_ndown) begin
                if (count_out < rollover_val) begin
                    next_count = count_out + ONE;
                end else if (sat_mode) begin
                    next_count = rollover_val;
                end else begin
                    // The range is 1..R, so wrapping up lands on 1, not on 0.
                    next_count = ONE;
                    next_wrap  = 1'b1;
                end
            end else begin
                if (sat_mode) begin
                    // Stepping down is clipped into range. At 1 or below the count holds.
                    if (count_out > ONE) begin
                        next_count = (dec_count > rollover_val) ? rollover_val : dec_count;
                    end
                end else if ((count_out > ONE) && (count_out <= rollover_val)) begin
                    next_count = dec_count;
                end else begin
                    // A count at the bottom or above R wraps to R. It never borrows past 0.
                    next_count = rollover_val;
                    next_wrap  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            count_out     <= next_count;
            // Compare the next count against the current R. This also picks up
            // changes to R on cycles where the count holds.
            rollover_flag <= (next_count == rollover_val);
            wrap_pulse    <= next_wrap;
        end
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// tb_flex_updown_counter
//   Directed self-checking bench for flex_updown_counter with NUM_CNT_BITS = 4.
//   Each expected value below was computed by hand from the counter's behaviour.
module tb_flex_updown_counter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       count_enable;
    logic       up_ndown;
    logic       sat_mode;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;
    logic       wrap_pulse;

    int unsigned errors = 0;
    int unsigned checks = 0;

    flex_updown_counter #(.NUM_CNT_BITS(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .up_ndown     (up_ndown),
        .sat_mode     (sat_mode),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input int c, input int f, input int w);
        check({tag, ".count"}, int'(count_out), c);
        check({tag, ".flag"},  int'(rollover_flag), f);
        check({tag, ".wrap"},  int'(wrap_pulse), w);
    endtask

    initial begin
        int exp_c[4];
        int exp_f[4];
        int exp_w[4];
        int wrap_seen;

        n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = 4'd0;
        count_enable = 1'b0; up_ndown = 1'b1; sat_mode = 1'b0; rollover_val = 4'd2;
        #12;
        check_out("reset", 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;

        // R=2, up, wrap mode: the count runs 1,2,1,2.
        exp_c = '{1, 2, 1, 2}; exp_f = '{0, 1, 0, 1}; exp_w = '{0, 0, 1, 0};
        count_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("r2up[%0d]", i), exp_c[i], exp_f[i], exp_w[i]);
        end

        // R=13: count from 0 up to 13, then wrap to 1.
        count_enable = 1'b0; clear = 1'b1; rollover_val = 4'd13;
        tick();
        check_out("clear13", 0, 0, 0);
        clear = 1'b0; count_enable = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        check_out("r13top", 13, 1, 0);
        tick();
        check_out("r13wrap", 1, 0, 1);

        // R=5: load 3, then count down 2,1,5,4.
        count_enable = 1'b0; load = 1'b1; load_val = 4'd3; rollover_val = 4'd5;
        tick();
        check_out("load3", 3, 0, 0);
        load = 1'b0; up_ndown = 1'b0; count_enable = 1'b1;
        exp_c = '{2, 1, 5, 4}; exp_f = '{0, 0, 1, 0}; exp_w = '{0, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("r5dn[%0d]", i), exp_c[i], exp_f[i], exp_w[i]);
        end

        // Saturate mode with R=7: counting up 10 times sticks at 7 and never wraps.
        count_enable = 1'b0; clear = 1'b1; rollover_val = 4'd7; sat_mode = 1'b1;
        tick();
        clear = 1'b0; up_ndown = 1'b1; count_enable = 1'b1;
        wrap_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wrap_pulse !== 1'b0) wrap_seen = 1;
        end
        check_out("sat7", 7, 1, 0);
        check("sat7.nowrap", wrap_seen, 0);
        // Saturate down from 2: 1, then hold at 1.
        count_enable = 1'b0; load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0; up_ndown = 1'b0; count_enable = 1'b1;
        tick();
        check_out("satdn1", 1, 0, 0);
        tick();
        check_out("satdn_hold", 1, 0, 0);
        // Saturate down from above R is clipped to R.
        count_enable = 1'b0; load = 1'b1; load_val = 4'd11;
        tick();
        load = 1'b0; count_enable = 1'b1;
        tick();
        check_out("satclip", 7, 1, 0);

        // Priority: clear beats load and enable.
        sat_mode = 1'b0; up_ndown = 1'b1; count_enable = 1'b0;
        load = 1'b1; load_val = 4'd4; rollover_val = 4'd6;
        tick();
        check_out("load4", 4, 0, 0);
        // With the count held at 4, changing R to 4 updates the flag on the next edge.
        load = 1'b0; rollover_val = 4'd4;
        tick();
        check_out("rrefresh", 4, 1, 0);
        rollover_val = 4'd6;
        clear = 1'b1; load = 1'b1; count_enable = 1'b1; load_val = 4'd9;
        tick();
        check_out("clrprio", 0, 0, 0);
        // Load beats enable. The loaded value may exceed R.
        clear = 1'b0; load_val = 4'd12;
        tick();
        check_out("load12", 12, 0, 0);
        load = 1'b0;
        tick();
        check_out("over_wrap", 1, 0, 1);

        // Asynchronous reset in the middle of a count.
        count_enable = 1'b0; clear = 1'b1; rollover_val = 4'd12;
        tick();
        clear = 1'b0; count_enable = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_out("pre_rst", 9, 0, 0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        rollover_val = 4'd0;
        for (int i = 0; i < 5; i++) tick();
        check_out("r0", 0, 1, 0);
        // Counting resumes from 0 after reset.
        rollover_val = 4'd3;
        tick();
        check_out("resume", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
